mem_burst_reader: RTL and testbench

Read-side burst engine for the small synchronous register-file memories written by the design's write ports (addr/din/en style). On a `start` command it issues sequential reads from `base_addr` for `len` words to a memory read port with fixed one-cycle read latency. It buffers the returned data in a 2-entry FIFO and presents it on a valid/ready stream with full backpressure, marking the final word with `out_last`. It sits between a storage array and any downstream consumer that drains that array.

---
 rtl/mem_burst_reader.sv | 136 +++++++++++++
 tb/tb_mem_burst_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - sequential burst reader from a 1-cycle-latency memory into a 2-entry valid/ready stream
module mem_burst_reader #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_q;
    logic [AW:0]   issue_cnt;
    logic [AW:0]   ret_cnt;
    logic          inflight;
    logic          flush_seen;

    logic [DW-1:0] fifo_data [2];
    logic [1:0]    fifo_last;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    fifo_count;

    logic          push;
    logic          pop;
    logic          credit;

    assign push      = inflight;
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;
    // A pop this cycle frees the slot the new read will land in next cycle.
    assign credit    = (({1'b0, inflight} + fifo_count) < 2'd2) | pop;

    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];
    assign rd_addr   = addr_q;
    assign busy      = (state != IDLE) & ~done;

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RUN : FLUSH;
                end
            end
            RUN: begin
                rd_en = (issue_cnt != '0) & credit;
                if (rd_en && (issue_cnt == CNT_ONE)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // flush_seen holds off a zero-length burst by one cycle
                if (flush_seen && !inflight && (fifo_count == 2'd0)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            inflight   <= 1'b0;
            flush_seen <= 1'b0;
        end else begin
            state      <= state_nxt;
            inflight   <= rd_en;
            flush_seen <= (state == FLUSH) && !done;
            if (state == IDLE && start) begin
                addr_q    <= base_addr;
                issue_cnt <= len;
                ret_cnt   <= len;
            end else begin
                if (rd_en) begin
                    addr_q    <= addr_q + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (push) begin
                    ret_cnt <= ret_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last  <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_last[wr_ptr] <= (ret_cnt == CNT_ONE);
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb/tb_mem_burst_reader.sv - randomized and directed bench for mem_burst_reader against a queue-based model
module tb_mem_burst_reader;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_burst_reader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    logic [7:0] mem [4];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

    int cyc = 0;
    int start_cyc = 0;
    int ready_mode = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = !((cyc - start_cyc) >= 2 && (cyc - start_cyc) <= 9);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: the burst is the list of words mem[(base+i)%4]; the stream must deliver them in order.
    int         exp_a [$];
    logic [7:0] exp_d [$];
    logic       m_busy = 0, m_done = 0, m_zero = 0, prev_hold = 0;
    int         m_issued = 0, m_popped = 0;
    int rd_rel [$], rd_a [$], acc_rel [$], acc_d [$], acc_l [$], done_rel [$];

    task automatic clear_logs();
        rd_rel.delete(); rd_a.delete(); acc_rel.delete();
        acc_d.delete(); acc_l.delete(); done_rel.delete();
    endtask

    always @(negedge clk) begin
        logic pop_now, last_pop, nb, nd;
        if (!rst) begin
            chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
            chk("rst_rd_en", rd_en, 0);     chk("rst_rd_addr", rd_addr, 0);
            chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
            chk("rst_last", out_last, 0);
            exp_a.delete(); exp_d.delete();
            m_busy = 0; m_done = 0; m_zero = 0; prev_hold = 0;
            m_issued = 0; m_popped = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (done) done_rel.push_back(cyc - start_cyc);
            pop_now = out_valid && out_ready;
            last_pop = 0;
            if (rd_en) begin
                if (exp_a.size() == 0) begin
                    chk("spurious_rd_en", rd_en, 0);
                end else begin
                    chk("rd_addr", rd_addr, exp_a.pop_front());
                end
                chk("credit", ((m_issued - m_popped) < 2) || pop_now, 1);
                m_issued++;
                rd_rel.push_back(cyc - start_cyc);
                rd_a.push_back(int'(rd_addr));
            end
            if (prev_hold) chk("hold_valid", out_valid, 1);
            if (out_valid) begin
                if (exp_d.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_d[0]);
                    chk("out_last", out_last, exp_d.size() == 1);
                end
            end
            if (pop_now && exp_d.size() > 0) begin
                void'(exp_d.pop_front());
                m_popped++;
                acc_rel.push_back(cyc - start_cyc);
                acc_d.push_back(int'(out_data));
                acc_l.push_back(int'(out_last));
                last_pop = (exp_d.size() == 0);
            end
            prev_hold = out_valid && !out_ready;
            nd = 0;
            nb = m_busy;
            if (m_zero) begin nd = 1; nb = 0; m_zero = 0; end
            if (last_pop) begin nd = 1; nb = 0; end
            if (start && !m_busy && !m_done) begin
                for (int i = 0; i < int'(len); i++) begin
                    exp_a.push_back((int'(base_addr) + i) % 4);
                    exp_d.push_back(mem[(int'(base_addr) + i) % 4]);
                end
                nb = 1;
                start_cyc = cyc;
                m_issued = 0;
                m_popped = 0;
                if (len == 0) m_zero = 1;
            end
            m_busy = nb;
            m_done = nd;
        end
    end

    task automatic run_burst(input int b, input int l, input int extra_k);
        int  n;
        logic got;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 2'(b); len = 3'(l);
        @(posedge clk); #1;
        start = 1'b0; base_addr = 2'($urandom); len = 3'($urandom);
        if (extra_k >= 0) begin
            repeat (extra_k) @(posedge clk);
            #1;
            start = 1'b1; base_addr = 2'($urandom); len = 3'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
        n = 0;
        got = 0;
        while (n < 300 && !got) begin
            @(negedge clk);
            if (done) got = 1;
            n++;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // Full-rate timing with out_ready held high.
    task automatic check_stream(input string tag, input int b, input int l);
        chk({tag, "_rd_count"}, rd_rel.size(), l);
        chk({tag, "_acc_count"}, acc_rel.size(), l);
        chk({tag, "_done_count"}, done_rel.size(), 1);
        for (int i = 0; i < l && i < rd_rel.size(); i++) begin
            chk({tag, "_rd_rel"}, rd_rel[i], i + 1);
            chk({tag, "_rd_a"}, rd_a[i], (b + i) % 4);
        end
        for (int i = 0; i < l && i < acc_rel.size(); i++) begin
            chk({tag, "_acc_rel"}, acc_rel[i], i + 3);
            chk({tag, "_acc_d"}, acc_d[i], mem[(b + i) % 4]);
            chk({tag, "_acc_l"}, acc_l[i], i == l - 1);
        end
        if (done_rel.size() > 0) chk({tag, "_done_rel"}, done_rel[0], l + 3);
    endtask

    initial begin
        mem[0] = 8'hA0; mem[1] = 8'hB1; mem[2] = 8'hC2; mem[3] = 8'hD3;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        clear_logs(); ready_mode = 0;
        run_burst(1, 3, -1);
        check_stream("t1", 1, 3);
        if (acc_d.size() == 3) begin
            chk("t1_w0", acc_d[0], 8'hB1);
            chk("t1_w1", acc_d[1], 8'hC2);
            chk("t1_w2", acc_d[2], 8'hD3);
        end
        if (done_rel.size() == 1) chk("t1_done6", done_rel[0], 6);

        clear_logs();
        run_burst(3, 6, -1);
        check_stream("t2", 3, 6);
        if (acc_d.size() == 6) begin
            chk("t2_w1", acc_d[1], 8'hA0);
            chk("t2_w5", acc_d[5], 8'hA0);
        end

        clear_logs(); ready_mode = 2;
        run_burst(1, 3, -1);
        ready_mode = 0;
        chk("t3_rd_count", rd_rel.size(), 3);
        chk("t3_acc_count", acc_rel.size(), 3);
        if (rd_rel.size() == 3) begin
            chk("t3_rd0", rd_rel[0], 1);
            chk("t3_rd1", rd_rel[1], 2);
            chk("t3_rd2", rd_rel[2], 10);
        end
        if (acc_rel.size() == 3) begin
            chk("t3_acc0", acc_rel[0], 10);
            chk("t3_acc2", acc_rel[2], 12);
            chk("t3_d0", acc_d[0], 8'hB1);
            chk("t3_d2", acc_d[2], 8'hD3);
        end
        if (done_rel.size() == 1) chk("t3_done", done_rel[0], 13);

        clear_logs();
        run_burst(2, 0, -1);
        chk("t4_rd_count", rd_rel.size(), 0);
        chk("t4_acc_count", acc_rel.size(), 0);
        chk("t4_done_count", done_rel.size(), 1);
        if (done_rel.size() == 1) chk("t4_done2", done_rel[0], 2);

        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 2'd1; len = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_rd_en", rd_en, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_rd_count", rd_rel.size(), 2);
        @(posedge clk); #1 rst = 1'b1;
        clear_logs();
        run_burst(0, 2, -1);
        check_stream("t5", 0, 2);

        clear_logs();
        run_burst(1, 3, 0);
        repeat (4) @(posedge clk);
        #1;
        check_stream("t6", 1, 3);

        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            int b, l, k;
            for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
            b = $urandom_range(0, 3);
            l = $urandom_range(0, 7);
            k = (l != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1;
            clear_logs();
            run_burst(b, l, k);
            chk("rand_words", acc_rel.size(), l);
            chk("rand_dones", done_rel.size(), 1);
        end
        ready_mode = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("model_drained", exp_d.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
